// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram counter with opcode dispatch, conditional branching,
// stall hold, start/done handshake and sticky illegal-address trap.
module micro_sequencer #(
  parameter int ROM_DEPTH  = 86,
  parameter int IDLE_ADDR  = 0,
  parameter int FETCH_ADDR = 1,
  parameter int END_ADDR   = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        z_flag,
  input  logic [7:0]  opcode,
  input  logic        BT,
  input  logic [1:0]  condition,
  input  logic [6:0]  jump_addr,
  output logic [15:0] reg_out,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [15:0] instr_count
);
  localparam logic [7:0] L_DEPTH = 8'(ROM_DEPTH);
  localparam logic [6:0] L_IDLE  = 7'(IDLE_ADDR);
  localparam logic [6:0] L_FETCH = 7'(FETCH_ADDR);
  localparam logic [6:0] L_END   = 7'(END_ADDR);
  logic [6:0]  r_addr;
  logic        r_busy, r_done, r_illegal;
  logic [15:0] r_count;
  logic        w_park, w_bad;
  logic [7:0]  w_jmp, w_inc, w_cond, w_tgt;
  logic [6:0]  w_next;
  // Targets are 8 bits wide so opcode[7] and the 127+1 carry both land out of range.
  always_comb begin
    w_park = r_addr == L_IDLE || r_addr == L_END;
    w_jmp  = {1'b0, jump_addr};
    w_inc  = {1'b0, r_addr} + 8'd1;
    w_cond = condition == 2'b00 ? w_jmp :
             condition == 2'b01 ? (z_flag ? w_jmp : w_inc) :
             condition == 2'b10 ? (!z_flag ? w_jmp : w_inc) :
             (z_flag ? w_jmp : {1'b0, r_addr});
    w_tgt  = BT ? opcode : w_cond;
    w_bad  = w_tgt >= L_DEPTH;
    w_next = w_park ? (start ? L_FETCH : r_addr) : w_bad ? L_IDLE : w_tgt[6:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else if (!stall) begin
      r_addr    <= w_next;
      r_busy    <= w_next != L_IDLE && w_next != L_END;
      r_done    <= w_next == L_END;
      r_illegal <= w_park ? r_illegal && !start : r_illegal || w_bad;
      r_count   <= w_park ? (start ? '0 : r_count) : r_count + {15'd0, BT};
    end
  end
  assign reg_out     = {9'd0, r_addr};
  assign busy        = r_busy;
  assign done        = r_done;
  assign illegal     = r_illegal;
  assign instr_count = r_count;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: drives a small microprogram ROM and checks the sequencer
// every cycle against an address-level reference model plus literal expectations.
module tb_micro_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, start, stall, z_flag;
  logic [7:0]  opcode;
  logic        BT;
  logic [1:0]  condition;
  logic [6:0]  jump_addr;
  logic [15:0] reg_out, instr_count;
  logic        busy, done, illegal;
  bit          rom_bt   [128];
  logic [1:0]  rom_cond [128];
  logic [6:0]  rom_jmp  [128];
  int          m_addr, m_cnt;
  bit          m_ill;
  int          checks = 0;
  int          errors = 0;

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .z_flag(z_flag),
    .opcode(opcode), .BT(BT), .condition(condition), .jump_addr(jump_addr),
    .reg_out(reg_out), .busy(busy), .done(done), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign BT        = rom_bt[reg_out[6:0]];
  assign condition = rom_cond[reg_out[6:0]];
  assign jump_addr = rom_jmp[reg_out[6:0]];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raw target of a word before the range check; 256 marks an opcode with bit 7 set.
  function automatic int f_tgt(input int a);
    int j;
    j = int'(rom_jmp[a]);
    if (rom_bt[a]) return opcode[7] ? 256 : int'(opcode[6:0]);
    case (rom_cond[a])
      2'd0:    return j;
      2'd1:    return z_flag ? j : a + 1;
      2'd2:    return !z_flag ? j : a + 1;
      default: return z_flag ? j : a;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr <= 0;
      m_ill  <= 1'b0;
      m_cnt  <= 0;
    end else if (!stall) begin
      if (m_addr == 0 || m_addr == 80) begin
        if (start) begin
          m_addr <= 1;
          m_ill  <= 1'b0;
          m_cnt  <= 0;
        end
      end else begin
        if (rom_bt[m_addr]) m_cnt <= (m_cnt + 1) % 65536;
        if (f_tgt(m_addr) >= 86) begin
          m_addr <= 0;
          m_ill  <= 1'b1;
        end else m_addr <= f_tgt(m_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_reg_out", reg_out, m_addr);
      chk("cyc_busy", busy, int'(m_addr != 0 && m_addr != 80));
      chk("cyc_done", done, int'(m_addr == 80));
      chk("cyc_illegal", illegal, m_ill);
      chk("cyc_count", instr_count, m_cnt);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      rom_bt[i]   = 1'b0;
      rom_cond[i] = 2'd0;
      rom_jmp[i]  = 7'd0;
    end
    rom_jmp[1] = 7'd2;
    rom_jmp[2] = 7'd3;
    rom_bt[3]  = 1'b1;
    rom_jmp[12] = 7'd60;
    rom_jmp[20] = 7'd100;
    rom_jmp[35] = 7'd80;
    rom_cond[60] = 2'd1; rom_jmp[60] = 7'd62;
    rom_jmp[61] = 7'd71;
    rom_jmp[62] = 7'd71;
    rom_cond[71] = 2'd3; rom_jmp[71] = 7'd74;
    rom_jmp[74] = 7'd35;
    rom_jmp[80] = 7'd80;
    rom_cond[85] = 2'd2; rom_jmp[85] = 7'd85;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; z_flag = 1'b0; opcode = 8'h0C;
    step(1);
    chk("rst_reg_out", reg_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_count", instr_count, 0);
    rst_n = 1'b1;
    step(2);
    chk("idle_hold", reg_out, 0);
    pulse_start();
    chk("start_fetch", reg_out, 1);
    chk("start_busy", busy, 1);
    step(1);
    chk("seq_2", reg_out, 2);
    step(2);
    chk("dispatch_0c", reg_out, 12);
    chk("dispatch_cnt", instr_count, 1);
    step(1);
    z_flag = 1'b1;
    step(1);
    chk("cond01_z1", reg_out, 62);
    step(1);
    z_flag = 1'b0;
    step(5);
    chk("poll_hold", reg_out, 71);
    chk("poll_busy", busy, 1);
    stall = 1'b1; z_flag = 1'b1;
    step(3);
    chk("stall_reg", reg_out, 71);
    chk("stall_cnt", instr_count, 1);
    stall = 1'b0;
    step(1);
    chk("poll_release", reg_out, 74);
    step(2);
    chk("end_reg", reg_out, 80);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    step(10);
    chk("end_park", reg_out, 80);
    chk("end_park_done", done, 1);
    start = 1'b1; stall = 1'b1;
    step(1);
    chk("start_stalled", reg_out, 80);
    stall = 1'b0;
    step(1);
    start = 1'b0;
    chk("restart_reg", reg_out, 1);
    chk("restart_done", done, 0);
    chk("restart_cnt", instr_count, 0);
    opcode = 8'h3C; z_flag = 1'b0;
    step(3);
    chk("dispatch_3c", reg_out, 60);
    step(1);
    chk("cond01_z0", reg_out, 61);
    z_flag = 1'b1;
    step(3);
    chk("mid_35", reg_out, 35);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reg", reg_out, 0);
    chk("async_busy", busy, 0);
    chk("async_cnt", instr_count, 0);
    @(negedge clk) rst_n = 1'b1;
    opcode = 8'h5A;
    pulse_start();
    step(3);
    chk("bad_op_reg", reg_out, 0);
    chk("bad_op_ill", illegal, 1);
    chk("bad_op_busy", busy, 0);
    chk("bad_op_cnt", instr_count, 1);
    step(2);
    chk("ill_sticky", illegal, 1);
    opcode = 8'h8C;
    pulse_start();
    chk("ill_cleared", illegal, 0);
    chk("cnt_cleared", instr_count, 0);
    step(3);
    chk("op_bit7_ill", illegal, 1);
    opcode = 8'h55;
    pulse_start();
    step(3);
    chk("at_85", reg_out, 85);
    step(1);
    chk("inc_over_reg", reg_out, 0);
    chk("inc_over_ill", illegal, 1);
    opcode = 8'h14;
    pulse_start();
    step(4);
    chk("jmp_over_reg", reg_out, 0);
    chk("jmp_over_ill", illegal, 1);
    opcode = 8'h03;
    pulse_start();
    step(2);
    chk("self_disp_cnt0", instr_count, 0);
    step(65535);
    chk("cnt_max", instr_count, 65535);
    step(1);
    chk("cnt_wrap", instr_count, 0);
    chk("self_disp_reg", reg_out, 3);
    opcode = 8'h50;
    step(1);
    chk("disp_end", done, 1);
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
